// File: rtl/rvfi_types_pkg.sv
// Shared RVFI record types for the commit tracker.
// Static fields come from dispatch, dynamic fields come from completion.
package rvfi_types_pkg;

    localparam int RVFI_ORDER_W = 64;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_rdata;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
    } rvfi_static_t;

    typedef struct packed {
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_dyn_t;

    typedef struct packed {
        rvfi_static_t st;
        rvfi_dyn_t    dyn;
    } rvfi_pkt_t;

endpackage

// File: rtl/rvfi_scrub.sv
// Zeroes RVFI fields that carry no architectural meaning so the
// monitor never sees stale or X data in them.
module rvfi_scrub
    import rvfi_types_pkg::*;
(
    input  rvfi_pkt_t pkt_i,
    output rvfi_pkt_t pkt_o
);

    // Mask unused register and memory data lanes.
    always_comb begin
        pkt_o = pkt_i;
        if (pkt_i.st.rs1_addr == 5'd0) pkt_o.dyn.rs1_rdata = '0;
        if (pkt_i.st.rs2_addr == 5'd0) pkt_o.dyn.rs2_rdata = '0;
        if (pkt_i.st.rd_addr == 5'd0)  pkt_o.dyn.rd_wdata  = '0;
        for (int b = 0; b < 4; b++) begin
            if (!pkt_i.dyn.mem_rmask[b]) pkt_o.dyn.mem_rdata[8*b +: 8] = 8'h00;
            if (!pkt_i.dyn.mem_wmask[b]) pkt_o.dyn.mem_wdata[8*b +: 8] = 8'h00;
        end
        if ((pkt_i.dyn.mem_rmask == 4'h0) && (pkt_i.dyn.mem_wmask == 4'h0))
            pkt_o.dyn.mem_addr = '0;
    end

endmodule

// File: rtl/rvfi_commit_tracker.sv
// In-order RVFI packet producer fed by dispatch and out-of-order completion.
// Define RVFI_X_SCRUB_EN to zero meaningless fields of committed packets.
module rvfi_commit_tracker
    import rvfi_types_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    output logic [IDX_W-1:0]        alloc_idx,
    input  rvfi_static_t            alloc_pkt,
    input  logic                    cmpl_valid,
    input  logic [IDX_W-1:0]        cmpl_idx,
    input  rvfi_dyn_t               cmpl_pkt,
    input  logic                    flush,
    output logic                    rvfi_valid,
    output logic [RVFI_ORDER_W-1:0] rvfi_order,
    output rvfi_pkt_t               rvfi_pkt
);

    localparam logic [IDX_W:0] PTR_ONE = 1;

    logic [IDX_W:0]          head_q, head_d;
    logic [IDX_W:0]          tail_q, tail_d;
    logic [DEPTH-1:0]        done_q, done_d;
    logic [RVFI_ORDER_W-1:0] order_cnt_q, order_cnt_d;
    logic                    rvfi_valid_q;
    logic [RVFI_ORDER_W-1:0] rvfi_order_q;
    rvfi_pkt_t               rvfi_pkt_q;

    rvfi_static_t st_q  [DEPTH];
    rvfi_dyn_t    dyn_q [DEPTH];

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             empty;
    logic             full;
    logic             commit;
    logic             alloc_fire;
    logic             cmpl_fire;
    rvfi_pkt_t        head_pkt;
    rvfi_pkt_t        head_out;

    assign head_idx   = head_q[IDX_W-1:0];
    assign tail_idx   = tail_q[IDX_W-1:0];
    assign empty      = (head_q == tail_q);
    assign full       = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign commit     = !empty && done_q[head_idx] && !flush;
    assign alloc_fire = alloc_valid && !full && !flush;
    assign cmpl_fire  = cmpl_valid && !flush;

    assign alloc_ready = !full;
    assign alloc_idx   = tail_idx;
    assign rvfi_valid  = rvfi_valid_q;
    assign rvfi_order  = rvfi_order_q;
    assign rvfi_pkt    = rvfi_pkt_q;

    assign head_pkt = {st_q[head_idx], dyn_q[head_idx]};

`ifdef RVFI_X_SCRUB_EN
    rvfi_scrub u_scrub (
        .pkt_i (head_pkt),
        .pkt_o (head_out)
    );
`else
    assign head_out = head_pkt;
`endif

    // Pointer, done-bit and order-counter next state.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        done_d      = done_q;
        order_cnt_d = order_cnt_q;
        if (flush) begin
            tail_d = head_q;
            done_d = '0;
        end else begin
            if (commit) begin
                head_d           = head_q + PTR_ONE;
                done_d[head_idx] = 1'b0;
                order_cnt_d      = order_cnt_q + 64'd1;
            end
            if (alloc_fire) begin
                tail_d           = tail_q + PTR_ONE;
                done_d[tail_idx] = 1'b0;
            end
            if (cmpl_fire) done_d[cmpl_idx] = 1'b1;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            done_q      <= '0;
            order_cnt_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            done_q      <= done_d;
            order_cnt_q <= order_cnt_d;
        end
    end

    // Entry payload storage; contents are qualified by the pointers.
    always_ff @(posedge clk) begin
        if (alloc_fire) st_q[tail_idx] <= alloc_pkt;
        if (cmpl_fire)  dyn_q[cmpl_idx] <= cmpl_pkt;
    end

    // Registered RVFI output; packet and order hold between commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvfi_valid_q <= 1'b0;
            rvfi_order_q <= '0;
            rvfi_pkt_q   <= '0;
        end else begin
            rvfi_valid_q <= commit;
            if (commit) begin
                rvfi_order_q <= order_cnt_q;
                rvfi_pkt_q   <= head_out;
            end
        end
    end

`ifndef SYNTHESIS
    logic [IDX_W:0] occ;
    logic [IDX_W:0] cmpl_off;
    assign occ      = tail_q - head_q;
    assign cmpl_off = {1'b0, cmpl_idx - head_idx};

    // A completion must target a live entry that is not yet done.
    always @(posedge clk) begin
        if (!rst && cmpl_fire) begin
            assert ((cmpl_off < occ) && !done_q[cmpl_idx])
            else $error("illegal completion of entry %0d", cmpl_idx);
        end
    end
`endif

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Directed table-driven bench for rvfi_commit_tracker.
// Hand-written sequences cover fill/wrap, flush, async reset and scrub.
module tb_rvfi_commit_tracker;
    import rvfi_types_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         alloc_valid;
    logic         alloc_ready;
    logic [3:0]   alloc_idx;
    rvfi_static_t alloc_pkt;
    logic         cmpl_valid;
    logic [3:0]   cmpl_idx;
    rvfi_dyn_t    cmpl_pkt;
    logic         flush;
    logic         rvfi_valid;
    logic [63:0]  rvfi_order;
    rvfi_pkt_t    rvfi_pkt;

    int checks = 0;
    int errors = 0;

    rvfi_commit_tracker #(.DEPTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_idx   (alloc_idx),
        .alloc_pkt   (alloc_pkt),
        .cmpl_valid  (cmpl_valid),
        .cmpl_idx    (cmpl_idx),
        .cmpl_pkt    (cmpl_pkt),
        .flush       (flush),
        .rvfi_valid  (rvfi_valid),
        .rvfi_order  (rvfi_order),
        .rvfi_pkt    (rvfi_pkt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [31:0] pc;
        logic        cv;
        logic [3:0]  ci;
        logic        ev;
        logic [63:0] eo;
        logic [31:0] epc;
        logic [31:0] epcw;
        logic        erdy;
        logic [3:0]  eidx;
    } vec_t;

    vec_t vt[$];

    function automatic rvfi_static_t mk_st(input logic [31:0] pc);
        rvfi_static_t s;
        s.inst     = 32'h0000_0013;
        s.pc_rdata = pc;
        s.rs1_addr = 5'd1;
        s.rs2_addr = 5'd2;
        s.rd_addr  = 5'd3;
        return s;
    endfunction

    function automatic rvfi_dyn_t mk_dyn(input logic [3:0] ci);
        rvfi_dyn_t d;
        d.rs1_rdata = 32'h1111_0000 | 32'(ci);
        d.rs2_rdata = 32'h2222_0000 | 32'(ci);
        d.rd_wdata  = 32'h3333_0000 | 32'(ci);
        d.pc_wdata  = 32'hC000_0000 | 32'(ci);
        d.mem_addr  = 32'h0;
        d.mem_rmask = 4'h0;
        d.mem_wmask = 4'h0;
        d.mem_rdata = 32'h0;
        d.mem_wdata = 32'h0;
        return d;
    endfunction

    task automatic add(input logic r, input logic av, input logic [31:0] pc,
                       input logic cv, input logic [3:0] ci, input logic ev,
                       input logic [63:0] eo, input logic [31:0] epc,
                       input logic [31:0] epcw, input logic erdy,
                       input logic [3:0] eidx);
        vec_t v;
        v.rst = r; v.av = av; v.pc = pc; v.cv = cv; v.ci = ci;
        v.ev = ev; v.eo = eo; v.epc = epc; v.epcw = epcw;
        v.erdy = erdy; v.eidx = eidx;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One clock cycle of stimulus; returns 1 time unit after the edge.
    task automatic drive(input logic r, input logic av, input logic [31:0] pc,
                         input logic cv, input logic [3:0] ci, input logic fl);
        rst         = r;
        alloc_valid = av;
        alloc_pkt   = mk_st(pc);
        cmpl_valid  = cv;
        cmpl_idx    = ci;
        cmpl_pkt    = mk_dyn(ci);
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        alloc_valid = 1'b0;
        alloc_pkt = '0;
        cmpl_valid = 1'b0;
        cmpl_idx = '0;
        cmpl_pkt = '0;
        flush = 1'b0;
        #1;
        chk("reset_valid", 64'(rvfi_valid), 64'd0);
        chk("reset_order", rvfi_order, 64'd0);
        chk("reset_ready", 64'(alloc_ready), 64'd1);
        chk("reset_idx", 64'(alloc_idx), 64'd0);
        chk("reset_pkt_zero", 64'(rvfi_pkt == '0), 64'd1);

        // In-order completion: three back-to-back commits.
        add(1, 0, 0,            0, 0, 0, 0, 0,            0,            1, 0);
        add(0, 1, 32'h60000000, 0, 0, 0, 0, 0,            0,            1, 1);
        add(0, 1, 32'h60000004, 0, 0, 0, 0, 0,            0,            1, 2);
        add(0, 1, 32'h60000008, 0, 0, 0, 0, 0,            0,            1, 3);
        add(0, 0, 0,            1, 0, 0, 0, 0,            0,            1, 3);
        add(0, 0, 0,            1, 1, 1, 0, 32'h60000000, 32'hC0000000, 1, 3);
        add(0, 0, 0,            1, 2, 1, 1, 32'h60000004, 32'hC0000001, 1, 3);
        add(0, 0, 0,            0, 0, 1, 2, 32'h60000008, 32'hC0000002, 1, 3);
        add(0, 0, 0,            0, 0, 0, 2, 0,            0,            1, 3);
        // Reverse completion: nothing until the head is done.
        add(1, 0, 0,            0, 0, 0, 0, 0,            0,            1, 0);
        add(0, 1, 32'h00000100, 0, 0, 0, 0, 0,            0,            1, 1);
        add(0, 1, 32'h00000104, 0, 0, 0, 0, 0,            0,            1, 2);
        add(0, 1, 32'h00000108, 0, 0, 0, 0, 0,            0,            1, 3);
        add(0, 1, 32'h0000010C, 0, 0, 0, 0, 0,            0,            1, 4);
        add(0, 0, 0,            1, 3, 0, 0, 0,            0,            1, 4);
        add(0, 0, 0,            1, 2, 0, 0, 0,            0,            1, 4);
        add(0, 0, 0,            1, 1, 0, 0, 0,            0,            1, 4);
        add(0, 0, 0,            1, 0, 0, 0, 0,            0,            1, 4);
        add(0, 0, 0,            0, 0, 1, 0, 32'h00000100, 32'hC0000000, 1, 4);
        add(0, 0, 0,            0, 0, 1, 1, 32'h00000104, 32'hC0000001, 1, 4);
        add(0, 0, 0,            0, 0, 1, 2, 32'h00000108, 32'hC0000002, 1, 4);
        add(0, 0, 0,            0, 0, 1, 3, 32'h0000010C, 32'hC0000003, 1, 4);
        add(0, 0, 0,            0, 0, 0, 3, 0,            0,            1, 4);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].av, vt[i].pc, vt[i].cv, vt[i].ci, 1'b0);
            chk($sformatf("row%0d_valid", i), 64'(rvfi_valid), 64'(vt[i].ev));
            chk($sformatf("row%0d_order", i), rvfi_order, vt[i].eo);
            chk($sformatf("row%0d_ready", i), 64'(alloc_ready), 64'(vt[i].erdy));
            chk($sformatf("row%0d_idx", i), 64'(alloc_idx), 64'(vt[i].eidx));
            if (vt[i].ev) begin
                chk($sformatf("row%0d_pc", i), 64'(rvfi_pkt.st.pc_rdata),
                    64'(vt[i].epc));
                chk($sformatf("row%0d_pcw", i), 64'(rvfi_pkt.dyn.pc_wdata),
                    64'(vt[i].epcw));
            end
        end

        // Fill to DEPTH, commit one, then wrap to index 0.
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            drive(0, 1, 32'h70000000 + 32'(4 * i), 0, 0, 0);
        chk("full_ready", 64'(alloc_ready), 64'd0);
        chk("full_idx", 64'(alloc_idx), 64'd0);
        drive(0, 1, 32'hBAD00000, 1, 0, 0);
        chk("full_blocked_ready", 64'(alloc_ready), 64'd0);
        chk("full_blocked_valid", 64'(rvfi_valid), 64'd0);
        drive(0, 1, 32'hBAD00004, 0, 0, 0);
        chk("full_commit_valid", 64'(rvfi_valid), 64'd1);
        chk("full_commit_pc", 64'(rvfi_pkt.st.pc_rdata), 64'h70000000);
        chk("full_freed_ready", 64'(alloc_ready), 64'd1);
        chk("wrap_idx", 64'(alloc_idx), 64'd0);
        drive(0, 1, 32'h7000_0040, 0, 0, 0);
        chk("wrap_full_again", 64'(alloc_ready), 64'd0);
        chk("wrap_next_idx", 64'(alloc_idx), 64'd1);

        // Flush after two commits; order continues at 2.
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            drive(0, 1, 32'h80000000 + 32'(4 * i), 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("pre_flush_order", rvfi_order, 64'd1);
        drive(0, 0, 0, 1, 2, 1);
        chk("flush_valid", 64'(rvfi_valid), 64'd0);
        chk("flush_idx", 64'(alloc_idx), 64'd2);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("post_flush_quiet", 64'(rvfi_valid), 64'd0);
        chk("post_flush_order_hold", rvfi_order, 64'd1);
        drive(0, 1, 32'h90000000, 0, 0, 0);
        chk("post_flush_idx", 64'(alloc_idx), 64'd3);
        drive(0, 0, 0, 1, 2, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("post_flush_valid", 64'(rvfi_valid), 64'd1);
        chk("post_flush_order", rvfi_order, 64'd2);
        chk("post_flush_pc", 64'(rvfi_pkt.st.pc_rdata), 64'h90000000);

        // Asynchronous reset in the middle of a commit burst.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 32'hA0000000, 0, 0, 0);
        drive(0, 1, 32'hA0000004, 0, 0, 0);
        drive(0, 1, 32'hA0000008, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 1, 2, 0);
        chk("pre_rst_valid", 64'(rvfi_valid), 64'd1);
        chk("pre_rst_order", rvfi_order, 64'd1);
        alloc_valid = 1'b0;
        cmpl_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(rvfi_valid), 64'd0);
        chk("async_rst_order", rvfi_order, 64'd0);
        chk("async_rst_idx", 64'(alloc_idx), 64'd0);
        chk("async_rst_ready", 64'(alloc_ready), 64'd1);
        drive(0, 0, 0, 0, 0, 0);
        chk("after_rst_quiet", 64'(rvfi_valid), 64'd0);

        // Data scrubbing on an instruction with rd=x0 and a partial store.
        drive(1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        alloc_valid = 1'b1;
        alloc_pkt = mk_st(32'hB0000000);
        alloc_pkt.rd_addr = 5'd0;
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        cmpl_valid = 1'b1;
        cmpl_idx = 4'd0;
        cmpl_pkt = mk_dyn(4'd0);
        cmpl_pkt.rd_wdata = 32'hDEADBEEF;
        cmpl_pkt.mem_addr = 32'h0000_1000;
        cmpl_pkt.mem_wmask = 4'b0011;
        cmpl_pkt.mem_wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1;
        cmpl_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("scrub_valid", 64'(rvfi_valid), 64'd1);
`ifdef RVFI_X_SCRUB_EN
        chk("scrub_rd_wdata", 64'(rvfi_pkt.dyn.rd_wdata), 64'h0);
        chk("scrub_mem_wdata", 64'(rvfi_pkt.dyn.mem_wdata), 64'h0000CCDD);
`else
        chk("pass_rd_wdata", 64'(rvfi_pkt.dyn.rd_wdata), 64'hDEADBEEF);
        chk("pass_mem_wdata", 64'(rvfi_pkt.dyn.mem_wdata), 64'hAABBCCDD);
`endif
        chk("scrub_mem_addr", 64'(rvfi_pkt.dyn.mem_addr), 64'h1000);
        chk("scrub_rs1", 64'(rvfi_pkt.dyn.rs1_rdata), 64'h11110000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvfi_commit_tracker.md
Name: rvfi_commit_tracker

Overview:
In-order RVFI packet producer: the transmitting end of the RVFI commit interface that the verification monitor consumes. Dispatch allocates one entry per instruction with its static fields; execute/memory units complete entries out of order with dynamic results. The block retires completed entries strictly in program order as single-cycle RVFI valid pulses carrying a monotonic order count. It sits beside the ROB in the out-of-order core, and its outputs drive the mon_itf signals.

Parameters:
DEPTH, 16, number of tracked in-flight instructions (power of two, >=2)
IDX_W, $clog2(DEPTH), entry index width (derived, localparam)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
alloc_valid  in  1  dispatch presents an instruction
alloc_ready  out  1  free entry exists; allocation occurs on valid&&ready
alloc_idx  out  IDX_W  index to be assigned (current tail)
alloc_pkt  in  rvfi_static_t  inst, pc_rdata, rs1_addr, rs2_addr, rd_addr
cmpl_valid  in  1  a functional unit completes an entry
cmpl_idx  in  IDX_W  entry being completed
cmpl_pkt  in  rvfi_dyn_t  rs1/rs2_rdata, rd_wdata, pc_wdata, mem_addr, mem_r/wmask, mem_r/wdata
flush  in  1  discard all uncommitted entries (mispredict/exception recovery)
rvfi_valid  out  1  one committed instruction this cycle
rvfi_order  out  64  commit sequence number
rvfi_pkt  out  rvfi_pkt_t  merged static+dynamic fields of the committed entry

Behaviour:
- Circular buffer with head/tail pointers of IDX_W+1 bits; empty when pointers are equal, full when index bits are equal and the MSBs differ. Per-entry done bit.
- Reset (asynchronous, active-high): head=tail=0, all done=0, rvfi_valid=0, rvfi_order=0, rvfi_pkt='0, alloc_ready=1.
- Alloc: on alloc_valid&&alloc_ready, write the static fields to entry[tail], clear its done bit, increment tail. alloc_ready = !full; it is combinational from the pointers only.
- Complete: on cmpl_valid, write the dynamic fields to entry[cmpl_idx] and set done. Completing an unallocated or already-done entry is illegal (simulation assertion).
- Commit: each cycle, if the buffer is not empty, done[head] is set, and flush=0, then on the next edge rvfi_valid<=1, rvfi_pkt<=entry[head], and head increments. rvfi_order<=order_cnt, then order_cnt increments. Otherwise rvfi_valid<=0, and rvfi_pkt/rvfi_order hold their previous values.
- Latency: a completion written at edge N to the head entry produces rvfi_valid high after edge N+1. Maximum of one commit per cycle.
- Same-cycle completion and commit check: done[head] is sampled pre-edge, so no bypass is required.
- Simultaneous alloc and commit while full: the commit frees an entry only on the next cycle; alloc_ready stays 0 in this cycle.
- Wrap-around: the pointers roll over naturally. Index DEPTH-1 is followed by 0.
- flush: at the edge, tail<=head, all done bits are cleared, rvfi_valid<=0, and allocation and completion in that cycle are ignored. order_cnt is preserved, and no order number is reused or skipped.
- rvfi_order begins at 0 and is gapless across flushes.
- pc_wdata always comes from the completion packet (the actual next PC), never a prediction.

Optional Feature:
RVFI_X_SCRUB_EN.
- Defined: on commit, rvfi_pkt forces the following to 0: rs1_rdata when rs1_addr==0, rs2_rdata when rs2_addr==0, rd_wdata when rd_addr==0, every mem_rdata byte whose rmask bit is 0, and every mem_wdata byte whose wmask bit is 0. mem_addr is forced to 0 when both masks are 0.
- Undefined: fields are passed through unmodified, and unused fields may carry X.

Decomposition:
- Package rvfi_types_pkg holds rvfi_static_t, rvfi_dyn_t, and rvfi_pkt_t (concatenation of static and dynamic), plus the constant RVFI_ORDER_W=64.
- One natural sub-module, rvfi_scrub: purely combinational, operating on rvfi_pkt_t. It is instantiated only under RVFI_X_SCRUB_EN.

Test Plan:
- Reset then 3 allocs (pc 0x60000000/04/08), completed in order 0,1,2 one per cycle → rvfi_valid pulses on 3 consecutive cycles, orders 0,1,2, pc_rdata matching.
- Alloc 4, complete idx 3,2,1 then 0 → no valid until idx 0 completes; 4 back-to-back commits follow 2 edges later, with orders 0..3.
- Fill DEPTH=16 → alloc_ready=0; one commit → alloc_ready returns to 1 the cycle after; the 17th alloc receives alloc_idx 0 (wrap).
- 5 allocs with 2 committed, then flush → no further valid; the next alloc receives alloc_idx 2, and its commit carries order 2.
- Assert rst mid-stream with entries done → rvfi_valid drops immediately, rvfi_order=0, alloc_idx=0.
- With RVFI_X_SCRUB_EN: rd_addr=0, rd_wdata=0xDEADBEEF, wmask=4'b0011, wdata=0xAABBCCDD → committed rd_wdata=0 and mem_wdata=0x0000CCDD.
